// File: rtl/dot_product_row_scheduler_pkg.sv
// Shared constants and FSM state type for the dot-product row scheduler.
package dot_product_row_scheduler_pkg;

    localparam int DEFAULT_ELEMENT_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH    = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        WAIT_RESULT,
        STORE
    } sched_state_t;

endpackage

// File: rtl/dot_product_row_scheduler_addr_gen.sv
// Row and package counters with an accumulated row-memory address.
// The address advances by one per issued package, so it equals row*multiples+pkg.
module sched_addr_gen #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  pkg_step,
    input  logic                  row_step,
    input  logic [ADDR_WIDTH-1:0] no_of_rows,
    input  logic [31:0]           no_of_multiples,
    output logic [ADDR_WIDTH-1:0] row,
    output logic [ADDR_WIDTH-1:0] pkg_addr,
    output logic                  last_pkg,
    output logic                  last_row
);

    logic [31:0]           pkg_reg;
    logic [ADDR_WIDTH-1:0] row_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pkg_reg  <= '0;
            row_reg  <= '0;
            addr_reg <= '0;
        end else begin
            if (pkg_step) begin
                addr_reg <= addr_reg + ADDR_WIDTH'(1);
                if (!last_pkg) begin
                    pkg_reg <= pkg_reg + 32'd1;
                end
            end
            if (row_step) begin
                row_reg <= row_reg + ADDR_WIDTH'(1);
                pkg_reg <= '0;
            end
        end
    end

    assign last_pkg = (pkg_reg == no_of_multiples - 32'd1);
    assign last_row = (row_reg == no_of_rows - ADDR_WIDTH'(1));
    assign row      = row_reg;
    assign pkg_addr = addr_reg;

endmodule

// File: rtl/dot_product_row_scheduler.sv
// Issues the packages of each row to the dot unit at a fixed spacing, waits
// for the row result (with timeout) and writes it into the result buffer.
module dot_product_row_scheduler
    import dot_product_row_scheduler_pkg::*;
#(
    parameter int ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int ISSUE_GAP     = 2,
    parameter int TIMEOUT       = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    no_of_rows,
    input  logic [31:0]              no_of_multiples,
    output logic [ADDR_WIDTH-1:0]    pkg_addr,
    output logic                     outsider_read_now,
    input  logic                     dp_finish,
    input  logic [ELEMENT_WIDTH-1:0] dp_result,
    output logic                     result_we,
    output logic [ADDR_WIDTH-1:0]    result_addr,
    output logic [ELEMENT_WIDTH-1:0] result_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    sched_state_t             state_reg, state_next;
    logic [ADDR_WIDTH-1:0]    rows_reg;
    logic [31:0]              mult_reg;
    logic [31:0]              gap_cnt_reg, gap_cnt_next;
    logic [31:0]              wait_cnt_reg, wait_cnt_next;
    logic [ELEMENT_WIDTH-1:0] result_data_reg;
    logic                     done_reg, done_next;
    logic                     error_reg, error_next;
    logic                     accept, capture, pkg_step, row_step;
    logic                     last_pkg, last_row;
    logic [ADDR_WIDTH-1:0]    row;

    sched_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk             (clk),
        .reset           (reset),
        .clear           (accept),
        .pkg_step        (pkg_step),
        .row_step        (row_step),
        .no_of_rows      (rows_reg),
        .no_of_multiples (mult_reg),
        .row             (row),
        .pkg_addr        (pkg_addr),
        .last_pkg        (last_pkg),
        .last_row        (last_row)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            rows_reg        <= '0;
            mult_reg        <= '0;
            gap_cnt_reg     <= '0;
            wait_cnt_reg    <= '0;
            result_data_reg <= '0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gap_cnt_reg  <= gap_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
            if (accept) begin
                rows_reg <= no_of_rows;
                mult_reg <= no_of_multiples;
            end
            if (capture) begin
                result_data_reg <= dp_result;
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        gap_cnt_next      = gap_cnt_reg;
        wait_cnt_next     = wait_cnt_reg;
        done_next         = 1'b0;
        error_next        = 1'b0;
        accept            = 1'b0;
        capture           = 1'b0;
        pkg_step          = 1'b0;
        row_step          = 1'b0;
        outsider_read_now = 1'b0;
        result_we         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (no_of_rows != '0 && no_of_multiples != '0) begin
                        accept     = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                outsider_read_now = 1'b1;
                pkg_step          = 1'b1;
                if (last_pkg) begin
                    wait_cnt_next = '0;
                    state_next    = WAIT_RESULT;
                end else if (ISSUE_GAP <= 1) begin
                    state_next = ISSUE;
                end else begin
                    gap_cnt_next = '0;
                    state_next   = GAP;
                end
            end
            GAP: begin
                // GAP lasts ISSUE_GAP-1 cycles so strobes land ISSUE_GAP apart
                if (gap_cnt_reg == 32'(ISSUE_GAP - 2)) begin
                    state_next = ISSUE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 32'd1;
                end
            end
            WAIT_RESULT: begin
                if (dp_finish) begin
                    capture    = 1'b1;
                    state_next = STORE;
                end else if (wait_cnt_reg == 32'(TIMEOUT - 1)) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 32'd1;
                end
            end
            STORE: begin
                result_we = 1'b1;
                if (last_row) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    row_step   = 1'b1;
                    state_next = ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign error       = error_reg;
    assign result_addr = row;
    assign result_data = result_data_reg;

endmodule

// File: tb/tb_dot_product_row_scheduler.sv
// Self-checking bench: table-driven jobs, randomized jobs and hand-written
// corner sequences checked against a timeline model of the scheduler.
module tb_dot_product_row_scheduler;

    localparam int EW  = 32;
    localparam int AW  = 16;
    localparam int GAP = 2;
    localparam int TO  = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] no_of_rows = '0;
    logic [31:0]   no_of_multiples = '0;
    logic [AW-1:0] pkg_addr;
    logic          outsider_read_now;
    logic          dp_finish = 1'b0;
    logic [EW-1:0] dp_result = '0;
    logic          result_we;
    logic [AW-1:0] result_addr;
    logic [EW-1:0] result_data;
    logic          busy, done, error;

    dot_product_row_scheduler #(
        .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .ISSUE_GAP(GAP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .no_of_rows(no_of_rows),
        .no_of_multiples(no_of_multiples), .pkg_addr(pkg_addr),
        .outsider_read_now(outsider_read_now), .dp_finish(dp_finish),
        .dp_result(dp_result), .result_we(result_we), .result_addr(result_addr),
        .result_data(result_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rows;
        int mult;
        int delay;
        int exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // observation logs for the current job
    int            strobe_cyc[$];
    logic [AW-1:0] strobe_addr[$];
    int            wr_cyc[$];
    logic [AW-1:0] wr_addr[$];
    logic [EW-1:0] wr_data[$];
    logic [EW-1:0] sent_data[$];
    int            delays_q[$];
    int done_n, err_n, both_n, busy_n, done_cyc, err_cyc;

    // dot-unit responder state
    bit resp_en, spur_en;
    int resp_mult, resp_delay, in_row, cd;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        strobe_cyc.delete(); strobe_addr.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        sent_data.delete(); delays_q.delete();
        done_n = 0; err_n = 0; both_n = 0; busy_n = 0; done_cyc = -1; err_cyc = -1;
        in_row = 0; cd = 0;
    endtask

    // One cycle: sample outputs mid-cycle, log them, then drive the next inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (outsider_read_now) begin strobe_cyc.push_back(cyc); strobe_addr.push_back(pkg_addr); end
        if (result_we) begin wr_cyc.push_back(cyc); wr_addr.push_back(result_addr); wr_data.push_back(result_data); end
        if (done) begin done_n++; done_cyc = cyc; end
        if (error) begin err_n++; err_cyc = cyc; end
        if (done && error) both_n++;
        if (busy) busy_n++;
        start = 1'b0;
        dp_finish = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                dp_finish = 1'b1;
                dp_result = $urandom;
                sent_data.push_back(dp_result);
            end
        end
        if (outsider_read_now && resp_en) begin
            in_row++;
            if (in_row == resp_mult) begin
                in_row = 0;
                cd = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 6));
                delays_q.push_back(cd);
            end
        end
        if (outsider_read_now && spur_en) begin
            dp_finish = 1'b1;
            dp_result = 32'hDEAD_BEEF;
        end
    endtask

    task automatic run_job(input int r, input int m, input int d, input int restart_at,
                           output int start_c);
        clear_logs();
        resp_mult = m; resp_delay = d;
        no_of_rows = AW'(r); no_of_multiples = 32'(m); start = 1'b1;
        start_c = cyc;
        for (int i = 0; i < 3000 && done_n == 0 && err_n == 0; i++) begin
            if (i == restart_at) begin
                start = 1'b1; no_of_rows = AW'(9); no_of_multiples = 32'd7;
            end
            step();
        end
        check("job_terminated", longint'(done_n + err_n > 0), 1);
        repeat (3) step();
    endtask

    // Expected timeline: first strobe one cycle after start, strobes GAP apart,
    // result sampled D cycles after the row's last strobe, written the next
    // cycle, next row's first strobe the cycle after that, done after the last write.
    task automatic verify_valid(input string tag, input int r, input int m, input int start_c);
        int exp_c, last_c, wr_c, idx;
        check({tag, "_strobes"}, strobe_addr.size(), r * m);
        check({tag, "_writes"}, wr_addr.size(), r);
        check({tag, "_err"}, err_n, 0);
        check({tag, "_done"}, done_n, 1);
        check({tag, "_both"}, both_n, 0);
        if (strobe_addr.size() == r * m && wr_addr.size() == r &&
            delays_q.size() == r && sent_data.size() == r) begin
            exp_c = start_c + 1; idx = 0; wr_c = start_c; last_c = start_c;
            for (int row = 0; row < r; row++) begin
                for (int p = 0; p < m; p++) begin
                    check({tag, "_paddr"}, strobe_addr[idx], longint'(AW'(row * m + p)));
                    check({tag, "_pcyc"}, strobe_cyc[idx], exp_c);
                    last_c = exp_c; exp_c += GAP; idx++;
                end
                wr_c = last_c + delays_q[row] + 1;
                check({tag, "_wcyc"}, wr_cyc[row], wr_c);
                check({tag, "_waddr"}, wr_addr[row], row);
                check({tag, "_wdata"}, wr_data[row], sent_data[row]);
                exp_c = wr_c + 1;
            end
            check({tag, "_done_cyc"}, done_cyc, wr_c + 1);
            check({tag, "_busy_cycles"}, busy_n, wr_c - start_c);
        end
    endtask

    task automatic verify_reject(input string tag, input int start_c);
        check({tag, "_err"}, err_n, 1);
        check({tag, "_err_cyc"}, err_cyc, start_c + 1);
        check({tag, "_strobes"}, strobe_addr.size(), 0);
        check({tag, "_busy"}, busy_n, 0);
        check({tag, "_done"}, done_n, 0);
    endtask

    vec_t vecs[6];
    int   sc;

    initial begin
        vecs[0] = '{rows: 2, mult: 3, delay: 5, exp_err: 0};
        vecs[1] = '{rows: 0, mult: 3, delay: 1, exp_err: 1};
        vecs[2] = '{rows: 3, mult: 0, delay: 1, exp_err: 1};
        vecs[3] = '{rows: 1, mult: 1, delay: 2, exp_err: 0};
        vecs[4] = '{rows: 3, mult: 2, delay: 1, exp_err: 0};
        vecs[5] = '{rows: 1, mult: 4, delay: 3, exp_err: 0};
        resp_en = 1'b1; spur_en = 1'b0;
        clear_logs();

        // reset state, with start held high to show reset overrides it
        no_of_rows = AW'(2); no_of_multiples = 32'd2; start = 1'b1;
        repeat (2) begin start = 1'b1; step(); end
        check("reset_outputs", {pkg_addr, outsider_read_now, result_we, result_addr,
                                result_data, busy, done, error}, 0);
        reset = 1'b0;
        step();
        check("reset_start_ignored", busy, 0);

        foreach (vecs[i]) begin
            run_job(vecs[i].rows, vecs[i].mult, vecs[i].delay, -1, sc);
            if (vecs[i].exp_err != 0) verify_reject($sformatf("vec%0d", i), sc);
            else verify_valid($sformatf("vec%0d", i), vecs[i].rows, vecs[i].mult, sc);
        end

        for (int j = 0; j < 6; j++) begin
            int r, m;
            r = $urandom_range(1, 4); m = $urandom_range(1, 5);
            run_job(r, m, 0, -1, sc);
            verify_valid($sformatf("rand%0d", j), r, m, sc);
        end

        // start again mid-job with different counts
        run_job(2, 2, 4, 3, sc);
        verify_valid("restart", 2, 2, sc);

        // spurious dp_finish while the single package is being issued
        spur_en = 1'b1;
        run_job(1, 1, 3, -1, sc);
        spur_en = 1'b0;
        verify_valid("spurious", 1, 1, sc);

        // dot unit never answers
        resp_en = 1'b0;
        run_job(1, 2, 1, -1, sc);
        resp_en = 1'b1;
        check("timeout_err", err_n, 1);
        check("timeout_writes", wr_addr.size(), 0);
        check("timeout_done", done_n, 0);
        check("timeout_busy", busy, 0);
        if (strobe_cyc.size() == 2) check("timeout_cyc", err_cyc, strobe_cyc[1] + TO + 1);
        else check("timeout_strobes", strobe_cyc.size(), 2);

        // reset during the GAP after row 1's first strobe
        clear_logs();
        resp_mult = 3; resp_delay = 3;
        no_of_rows = AW'(2); no_of_multiples = 32'd3; start = 1'b1;
        for (int i = 0; i < 200 && strobe_addr.size() < 4; i++) step();
        check("rst_pre_strobes", strobe_addr.size(), 4);
        step();
        check("rst_in_gap", {busy, outsider_read_now}, 2'b10);
        reset = 1'b1;
        step();
        check("rst_outputs", {pkg_addr, outsider_read_now, result_we, result_addr,
                              result_data, busy, done, error}, 0);
        reset = 1'b0; cd = 0;
        repeat (30) step();
        check("rst_no_strobes", strobe_addr.size(), 4);
        check("rst_no_writes", wr_addr.size(), 1);
        check("rst_no_done", done_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
